// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: opcodes, FSM encoding and decode helpers.
package mem_access_pkg;

    localparam logic [4:0] OP_LD  = 5'h10;
    localparam logic [4:0] OP_ST  = 5'h11;
    localparam logic [4:0] OP_BR  = 5'h12;
    localparam logic [4:0] OP_JMP = 5'h13;

    // Encoding is visible on ESTADO, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERR    = 3'd7
    } state_e;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_branch_taken(input logic [4:0] op, input logic cond);
        return (op == OP_JMP) || ((op == OP_BR) && cond);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access timeout counter: counts cycles while enabled, flags the last allowed cycle.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins over enable; saturate at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: captures execute results, runs a load/store handshake with
// timeout, resolves branches and presents registered results to write-back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              VALID_IN,
    input  logic [31:0]       ALU_IN,
    input  logic [DATA_W-1:0] REG_B_IN,
    input  logic [4:0]        OPCD_IN,
    input  logic [4:0]        ADDR_REG_IN,
    input  logic              OPT_BIT_IN,
    input  logic              COND_IN,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [DATA_W-1:0] LMD_OUT,
    output logic [31:0]       ALU_OUT,
    output logic [4:0]        OPCD_OUT,
    output logic [4:0]        ADDR_REG_OUT,
    output logic              OPT_BIT_OUT,
    output logic              BR_TAKEN,
    output logic [ADDR_W-1:0] BR_TARGET,
    output logic              VALID_OUT,
    output logic              BUSY,
    output logic              MEM_ERR,
    output logic [2:0]        ESTADO
);

    state_e state_q, state_d;

    // Captured execute-stage results.
    logic [31:0]       alu_q, alu_d;
    logic [DATA_W-1:0] regb_q, regb_d;
    logic [4:0]        opcd_q, opcd_d;
    logic [4:0]        addr_reg_q, addr_reg_d;
    logic              opt_q, opt_d;
    logic              cond_q, cond_d;
    logic              capture;

    // Registered outputs.
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] lmd_q, lmd_d;
    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] br_target_q, br_target_d;
    logic              valid_out_q, valid_out_d;
    logic              busy_q, busy_d;
    logic              mem_err_q, mem_err_d;

    logic ctr_clr, ctr_en, ctr_tc;

    assign capture = (state_q == ST_IDLE) && VALID_IN;
    assign ctr_en  = (state_q == ST_ACCESS);
    assign ctr_clr = (state_q != ST_ACCESS);

    mem_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_ctr (
        .clk_i (CLK),
        .rst_ni(RST),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_o  (ctr_tc)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; an ACK in the terminal cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (VALID_IN) begin
                    state_d = is_mem_op(OPCD_IN) ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (MEM_ACK) begin
                    state_d = ST_DONE;
                end else if (ctr_tc) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Input capture, only while idle; held for the rest of the operation.
    always_comb begin
        alu_d      = alu_q;
        regb_d     = regb_q;
        opcd_d     = opcd_q;
        addr_reg_d = addr_reg_q;
        opt_d      = opt_q;
        cond_d     = cond_q;
        if (capture) begin
            alu_d      = ALU_IN;
            regb_d     = REG_B_IN;
            opcd_d     = OPCD_IN;
            addr_reg_d = ADDR_REG_IN;
            opt_d      = OPT_BIT_IN;
            cond_d     = COND_IN;
        end
    end

    // Output next-values, derived from the state being entered so every output is a flop.
    always_comb begin
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        lmd_d       = lmd_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        valid_out_d = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        mem_err_d   = mem_err_q || (state_d == ST_ERR);

        // Request stays asserted with stable address/data for the whole ACCESS stay.
        if (state_d == ST_ACCESS) begin
            mem_addr_d  = alu_d[ADDR_W-1:0];
            mem_wdata_d = regb_d;
            mem_rd_d    = (opcd_d == OP_LD);
            mem_wr_d    = (opcd_d == OP_ST);
        end

        if ((state_q == ST_ACCESS) && MEM_ACK && (opcd_q == OP_LD)) begin
            lmd_d = MEM_RDATA;
        end

        if (state_d == ST_DONE) begin
            valid_out_d = 1'b1;
            br_taken_d  = is_branch_taken(opcd_d, cond_d);
            br_target_d = alu_d[ADDR_W-1:0];
        end
    end

    // Capture and output registers; reset clears everything, dropping any request at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_q       <= '0;
            regb_q      <= '0;
            opcd_q      <= '0;
            addr_reg_q  <= '0;
            opt_q       <= 1'b0;
            cond_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            lmd_q       <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            alu_q       <= alu_d;
            regb_q      <= regb_d;
            opcd_q      <= opcd_d;
            addr_reg_q  <= addr_reg_d;
            opt_q       <= opt_d;
            cond_q      <= cond_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            lmd_q       <= lmd_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            valid_out_q <= valid_out_d;
            busy_q      <= busy_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign MEM_ADDR     = mem_addr_q;
    assign MEM_WDATA    = mem_wdata_q;
    assign MEM_RD       = mem_rd_q;
    assign MEM_WR       = mem_wr_q;
    assign LMD_OUT      = lmd_q;
    assign ALU_OUT      = alu_q;
    assign OPCD_OUT     = opcd_q;
    assign ADDR_REG_OUT = addr_reg_q;
    assign OPT_BIT_OUT  = opt_q;
    assign BR_TAKEN     = br_taken_q;
    assign BR_TARGET    = br_target_q;
    assign VALID_OUT    = valid_out_q;
    assign BUSY         = busy_q;
    assign MEM_ERR      = mem_err_q;
    assign ESTADO       = state_q;

endmodule
